counter_scheduler: RTL and testbench



---
 rtl/counter_scheduler_pkg.sv | 22 ++
 rtl/counter_scheduler_rr_arbiter.sv | 31 +++
 rtl/counter_scheduler.sv | 117 +++++++++++
 tb/tb_counter_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_scheduler_pkg.sv
// Shared types and helpers for the counter scheduler and its arbiter.
package counter_scheduler_pkg;

    localparam int CW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One-hot (up to 8 bits) to binary index; all-zero maps to 0.
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module counter_scheduler_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   first;
    logic [2*N_REQ-1:0] pick_dbl;

    // Rotate requests so ptr lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot   = N_REQ'({req, req} >> ptr);
        first = '0;
        valid = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && rot[j]) begin
                first[j] = 1'b1;
                valid    = 1'b1;
            end
        end
        pick_dbl = {{N_REQ{1'b0}}, first} << ptr;
        pick     = pick_dbl[N_REQ-1:0] | pick_dbl[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one external interval counter among N_REQ requesters.
//
// state  | meaning
// IDLE   | counter held at 0, arbitrate pending requests
// COUNT  | counter running for the owner, compare against latched duration
// DONE   | one-cycle done pulse to the owner, counter cleared
module counter_scheduler
    import counter_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CW    = CW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*CW-1:0] dur,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic               cnt_mode,
    input  logic [CW-1:0]      cnt_value
);

    localparam int PW = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_next;
    logic [CW-1:0]    dur_q, dur_d;
    logic [CW-1:0]    dur_pick;
    logic [N_REQ-1:0] pick;
    logic             pick_valid;
    logic             owner_req;

    counter_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Select the duration of the requester the arbiter picked.
    always_comb begin
        dur_pick = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) dur_pick = dur[i*CW +: CW];
        end
    end

    assign owner_req  = |(req & grant);
    assign owner_next = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);

    // Outputs are decoded from registered state only, never from req.
    assign busy     = (state_q == ST_COUNT) || (state_q == ST_DONE);
    assign cnt_mode = (state_q == ST_COUNT);
    assign done     = (state_q == ST_DONE) ? grant : '0;

    // Next-state logic; an owner dropping req aborts without a done pulse.
    always_comb begin
        state_d = state_q;
        grant_d = grant;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        dur_d   = dur_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_COUNT;
                    grant_d = pick;
                    owner_d = PW'(oh_to_idx(8'(pick)));
                    dur_d   = dur_pick;
                end
            end
            ST_COUNT: begin
                if (!owner_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_next;
                end else if (cnt_value >= dur_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = owner_next;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant, owner, pointer and latched duration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            dur_q   <= dur_d;
        end
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler with a behavioural shared counter.
module tb_counter_scheduler;

    localparam int N_REQ = 4;
    localparam int CW    = 32;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [N_REQ-1:0]      req = '0;
    logic [N_REQ*CW-1:0]   dur = '0;
    logic [N_REQ-1:0]      grant;
    logic [N_REQ-1:0]      done;
    logic                  busy;
    logic                  cnt_mode;
    logic [CW-1:0]         cnt_value;
    logic [CW-1:0]         cnt;
    logic                  force_max = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    counter_scheduler #(.N_REQ(N_REQ), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .dur       (dur),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .cnt_mode  (cnt_mode),
        .cnt_value (cnt_value)
    );

    always #5 clk = ~clk;

    // Shared counter: mode 0 clears/holds at zero, mode 1 increments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         cnt <= '0;
        else if (cnt_mode) cnt <= cnt + 1;
        else               cnt <= '0;
    end

    assign cnt_value = force_max ? '1 : cnt;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_dur(input int i, input logic [CW-1:0] v);
        dur[i*CW +: CW] = v;
    endtask

    task automatic do_reset();
        req = '0; dur = '0; force_max = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        tests_run++; if (done !== 4'b0000) begin tests_failed++; $display("FAIL reset_done: got %b expected 0000", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (cnt_mode !== 1'b0) begin tests_failed++; $display("FAIL reset_cnt_mode: got %b expected 0", cnt_mode); end
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        int n, modes;
        logic [CW-1:0] maxc;
        do_reset();
        set_dur(0, 5); req = 4'b0001;
        step();
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL single_grant: got %b expected 0001", grant); end
        set_dur(0, 1);
        n = 1; modes = 0; maxc = '0;
        while (done === 4'b0000 && n < 40) begin
            if (cnt_mode) modes++;
            if (cnt_mode && cnt_value > maxc) maxc = cnt_value;
            step(); n++;
        end
        tests_run++; if (n != 7) begin tests_failed++; $display("FAIL single_done_cycle: got %0d expected 7", n); end
        tests_run++; if (modes != 6) begin tests_failed++; $display("FAIL single_mode_cycles: got %0d expected 6", modes); end
        tests_run++; if (maxc != 5) begin tests_failed++; $display("FAIL single_max_count: got %0d expected 5", maxc); end
        tests_run++; if (done !== 4'b0001) begin tests_failed++; $display("FAIL single_done: got %b expected 0001", done); end
        tests_run++; if (grant !== 4'b0001 || cnt_mode !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_done_state: got grant=%b mode=%b busy=%b expected 0001/0/1", grant, cnt_mode, busy); end
        req = 4'b0000;
        step();
        tests_run++; if (grant !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin tests_failed++; $display("FAIL single_after: got grant=%b busy=%b done=%b expected 0000/0/0000", grant, busy, done); end
    endtask

    task automatic test_round_robin();
        logic [3:0] order [4];
        int done_t [4];
        int lows [$];
        int k, g, low_run;
        bit seen_high;
        logic prev_mode;
        logic [3:0] prev_grant;
        do_reset();
        for (int i = 0; i < 4; i++) begin set_dur(i, 2); order[i] = '0; done_t[i] = 0; end
        req = 4'b1111;
        k = 0; g = 0; low_run = 0; seen_high = 0; prev_mode = 0; prev_grant = '0;
        for (int c = 0; c < 80 && k < 4; c++) begin
            step();
            if (grant !== 4'b0000 && prev_grant === 4'b0000 && g < 4) begin order[g] = grant; g++; end
            if (cnt_mode) begin
                if (!prev_mode && seen_high) lows.push_back(low_run);
                seen_high = 1; low_run = 0;
            end else if (seen_high) begin
                low_run++;
            end
            if (done !== 4'b0000) begin done_t[k] = c; k++; req = req & ~done; end
            prev_mode = cnt_mode; prev_grant = grant;
        end
        tests_run++; if (k != 4) begin tests_failed++; $display("FAIL rr_done_count: got %0d expected 4", k); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (order[i] !== (4'b0001 << i)) begin tests_failed++; $display("FAIL rr_order[%0d]: got %b expected %b", i, order[i], 4'b0001 << i); end
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (done_t[i+1] - done_t[i] != 5) begin tests_failed++; $display("FAIL rr_done_gap[%0d]: got %0d expected 5", i, done_t[i+1] - done_t[i]); end
        end
        tests_run++; if (lows.size() != 3) begin tests_failed++; $display("FAIL rr_low_runs: got %0d expected 3", lows.size()); end
        foreach (lows[i]) begin
            tests_run++; if (lows[i] != 2) begin tests_failed++; $display("FAIL rr_low_len[%0d]: got %0d expected 2", i, lows[i]); end
        end
        req = '0; step();
    endtask

    task automatic test_dur_zero();
        int n;
        logic [CW-1:0] maxc;
        do_reset();
        set_dur(0, 0); req = 4'b0001;
        step();
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL zero_grant: got %b expected 0001", grant); end
        n = 1; maxc = '0;
        while (done === 4'b0000 && n < 20) begin
            if (cnt_mode && cnt_value > maxc) maxc = cnt_value;
            step(); n++;
        end
        tests_run++; if (n != 2) begin tests_failed++; $display("FAIL zero_done_cycle: got %0d expected 2", n); end
        tests_run++; if (maxc != 0) begin tests_failed++; $display("FAIL zero_max_count: got %0d expected 0", maxc); end
        req = '0; step();
    endtask

    task automatic test_abort();
        int n;
        bit saw_done;
        do_reset();
        set_dur(1, 100); set_dur(2, 3); req = 4'b0010;
        step();
        tests_run++; if (grant !== 4'b0010) begin tests_failed++; $display("FAIL abort_grant: got %b expected 0010", grant); end
        n = 0; saw_done = 0;
        while (cnt_value != 40 && n < 200) begin
            if (done !== 4'b0000) saw_done = 1;
            if (cnt_value == 10) req = 4'b1010;
            step(); n++;
        end
        tests_run++; if (cnt_value != 40 || grant !== 4'b0010) begin tests_failed++; $display("FAIL abort_reach40: got cnt=%0d grant=%b expected 40/0010", cnt_value, grant); end
        req = 4'b0000;
        step();
        tests_run++; if (grant !== 4'b0000 || busy !== 1'b0 || cnt_mode !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: got grant=%b busy=%b mode=%b expected 0000/0/0", grant, busy, cnt_mode); end
        tests_run++; if (saw_done || done !== 4'b0000) begin tests_failed++; $display("FAIL abort_no_done: got saw=%0d done=%b expected 0/0000", saw_done, done); end
        req = 4'b0111;
        step();
        tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL abort_next_ptr: got %b expected 0100", grant); end
        req = '0; step();
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        set_dur(0, 50); req = 4'b0001;
        step();
        n = 0;
        while (cnt_value != 17 && n < 100) begin step(); n++; end
        tests_run++; if (cnt_value != 17 || busy !== 1'b1) begin tests_failed++; $display("FAIL rmid_reach17: got cnt=%0d busy=%b expected 17/1", cnt_value, busy); end
        reset = 1'b1;
        #1;
        tests_run++; if (grant !== 4'b0000 || busy !== 1'b0 || cnt_mode !== 1'b0 || done !== 4'b0000) begin tests_failed++; $display("FAIL rmid_async: got grant=%b busy=%b mode=%b done=%b expected 0000/0/0/0000", grant, busy, cnt_mode, done); end
        req = '0;
        step();
        reset = 1'b0;
        step();
        set_dur(1, 3); req = 4'b0010;
        step();
        tests_run++; if (grant !== 4'b0010) begin tests_failed++; $display("FAIL rmid_regrant: got %b expected 0010", grant); end
        n = 1;
        while (done === 4'b0000 && n < 20) begin step(); n++; end
        tests_run++; if (n != 5 || done !== 4'b0010) begin tests_failed++; $display("FAIL rmid_done: got cycle=%0d done=%b expected 5/0010", n, done); end
        req = '0; step();
    endtask

    task automatic test_rr_hold();
        int n;
        do_reset();
        set_dur(0, 2); set_dur(2, 2); req = 4'b0101;
        step();
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL hold_first: got %b expected 0001", grant); end
        n = 0;
        while (done === 4'b0000 && n < 20) begin step(); n++; end
        tests_run++; if (done !== 4'b0001) begin tests_failed++; $display("FAIL hold_done0: got %b expected 0001", done); end
        step();
        n = 0;
        while (grant === 4'b0000 && n < 10) begin step(); n++; end
        tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL hold_next: got %b expected 0100", grant); end
        req = '0; step();
    endtask

    task automatic test_saturation();
        do_reset();
        set_dur(0, '1); force_max = 1'b1; req = 4'b0001;
        step();
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL sat_grant: got %b expected 0001", grant); end
        step();
        tests_run++; if (done !== 4'b0001) begin tests_failed++; $display("FAIL sat_done: got %b expected 0001", done); end
        req = '0; force_max = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_dur_zero();
        test_abort();
        test_reset_mid();
        test_rr_hold();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
